// File: rtl/bcd_scan4.sv
// Four-digit multiplexed BCD display scanner: prescaled slot rotation, per-frame
// input snapshot, leading-zero blanking and registered active-low drive outputs.
module bcd_scan4 #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_r;
    logic [1:0]  idx_r;
    logic [15:0] snap_r;
    logic [3:0]  snap_dp_r;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_r;
    logic        frame_done_r;

    logic        wrap_s;
    logic        frame_start_s;
    logic [3:0]  digit_s;
    logic        blank_sel_s;
    logic        lz3_s;
    logic        lz2_s;
    logic        lz1_s;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic        dp_s;
    logic        frame_done_s;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = 7'b1111110;
        endcase
        return pat;
    endfunction

    assign wrap_s        = (cnt_r == CNT_MAX);
    assign frame_start_s = enable && (idx_r == 2'd0) && (cnt_r == 16'd0);

    // Prescaler and slot index; both freeze while the scan is disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'd0;
            idx_r <= 2'd0;
        end else if (enable) begin
            if (wrap_s) begin
                cnt_r <= 16'd0;
                idx_r <= idx_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + 16'd1;
                idx_r <= idx_r;
            end
        end else begin
            cnt_r <= cnt_r;
            idx_r <= idx_r;
        end
    end

    // Input snapshot, taken only at frame start so a frame never mixes input states.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_r    <= 16'd0;
            snap_dp_r <= 4'd0;
        end else if (frame_start_s) begin
            snap_r    <= {digit3, digit2, digit1, digit0};
            snap_dp_r <= dp_en;
        end else begin
            snap_r    <= snap_r;
            snap_dp_r <= snap_dp_r;
        end
    end

    assign lz3_s = blank_lz && (snap_r[15:12] == 4'd0);
    assign lz2_s = lz3_s && (snap_r[11:8] == 4'd0);
    assign lz1_s = lz2_s && (snap_r[7:4] == 4'd0);

    // Next-cycle display drive for the current slot.
    always_comb begin
        an_s         = 4'b1111;
        seg_s        = 7'b1111111;
        dp_s         = 1'b1;
        digit_s      = 4'd0;
        blank_sel_s  = 1'b0;
        frame_done_s = enable && wrap_s && (idx_r == 2'd3);
        case (idx_r)
            2'd0: begin digit_s = snap_r[3:0];   blank_sel_s = 1'b0;  end
            2'd1: begin digit_s = snap_r[7:4];   blank_sel_s = lz1_s; end
            2'd2: begin digit_s = snap_r[11:8];  blank_sel_s = lz2_s; end
            2'd3: begin digit_s = snap_r[15:12]; blank_sel_s = lz3_s; end
            default: begin digit_s = 4'd0;       blank_sel_s = 1'b1;  end
        endcase
        // Slot start is dead time so the previous digit cannot ghost into this one.
        if (!enable || (cnt_r == 16'd0) || blank_sel_s) begin
            an_s  = 4'b1111;
            seg_s = 7'b1111111;
            dp_s  = 1'b1;
        end else begin
            an_s  = ~(4'b0001 << idx_r);
            seg_s = seg_encode(digit_s);
            dp_s  = ~snap_dp_r[idx_r];
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_r         <= 4'b1111;
            seg_r        <= 7'b1111111;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_scan4.sv
// Scoreboard bench for bcd_scan4: an abstract display model pushes expected outputs
// each clock; a negedge monitor pops and compares against the DUT.
module tb_bcd_scan4;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] digit0 = 4'd0, digit1 = 4'd0, digit2 = 4'd0, digit3 = 4'd0;
    logic [3:0] dp_en = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    bcd_scan4 #(.SCAN_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_en(dp_en), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    int         m_cnt = 0;
    int         m_idx = 0;
    logic [3:0] m_snap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] m_dp = 4'd0;

    // Reference model: what each digit slot should show, stepped once per clock.
    always @(posedge clock) begin
        exp_t e;
        int   top;
        e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
        cyc++;
        if (!reset) begin
            m_cnt = 0;
            m_idx = 0;
            m_snap = '{4'd0, 4'd0, 4'd0, 4'd0};
            m_dp = 4'd0;
        end else begin
            e.fd = enable && (m_idx == 3) && (m_cnt == DIV - 1);
            top = 0;
            for (int k = 1; k < 4; k++) if (m_snap[k] != 4'd0) top = k;
            if (enable && m_cnt != 0 && !(blank_lz && m_idx > top)) begin
                e.an  = 4'b1111;
                e.an[m_idx] = 1'b0;
                e.seg = (m_snap[m_idx] > 4'd9) ? 7'b1111110 : seg_tab[m_snap[m_idx]];
                e.dp  = !m_dp[m_idx];
            end
            if (enable) begin
                if (m_cnt == 0 && m_idx == 0) begin
                    m_snap = '{digit0, digit1, digit2, digit3};
                    m_dp = dp_en;
                end
                m_cnt = (m_cnt + 1) % DIV;
                if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compare every presented output word against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                n_fail++;
                $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    task automatic check_reset_vals(input string name);
        n_tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got an=%b seg=%b dp=%b fd=%b want 1111/1111111/1/0",
                     name, an, seg, dp, frame_done);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic wait_state(input int idx, input int cnt);
        int k;
        k = 0;
        while (!(m_idx == idx && m_cnt == cnt) && k < 100) begin
            run(1);
            k++;
        end
        n_tests++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL wait_state timeout got idx=%0d cnt=%0d want idx=%0d cnt=%0d",
                     m_idx, m_cnt, idx, cnt);
        end
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 check_reset_vals("reset_async_start");
        run(3);
        check_reset_vals("reset_held");
        set_digits(4'd0, 4'd0, 4'd3, 4'd7);
        blank_lz = 1'b1;
        dp_en = 4'b0000;
        enable = 1'b1;
        reset = 1'b1;
        run(34);
        blank_lz = 1'b0;
        run(32);
        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        blank_lz = 1'b1;
        run(32);
        // Mid-frame change must wait for the next frame start.
        set_digits(4'd0, 4'd0, 4'd0, 4'd2);
        run(16);
        wait_state(2, 1);
        digit0 = 4'd9;
        run(24);
        set_digits(4'd0, 4'd0, 4'hC, 4'd1);
        dp_en = 4'b0010;
        run(32);
        // Pause mid-slot and resume.
        wait_state(1, 2);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(40);
        // Reset in the middle of slot 3.
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        dp_en = 4'b1000;
        run(16);
        wait_state(3, 2);
        reset = 1'b0;
        #1 check_reset_vals("reset_async_mid");
        exp_q.delete();
        run(3);
        check_reset_vals("reset_mid_held");
        reset = 1'b1;
        run(20);
        for (int i = 0; i < 300; i++) begin
            if ((i % 7) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ((i % 11) == 0) dp_en = 4'($urandom_range(0, 15));
            if ((i % 23) == 0) blank_lz = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
            run(1);
        end
        enable = 1'b1;
        run(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
